// File: rtl/joy_pkg.sv
// Shared types and constants for the Oric joystick port controller.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package joy_pkg;

    // Joystick adapter plugged into the Oric printer port.
    typedef enum logic [1:0] {
        ADP_NONE = 2'd0,
        ADP_PASE = 2'd1,
        ADP_IJK  = 2'd2,
        ADP_RSVD = 2'd3
    } adapter_t;

    // Port controller sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DRIVE  = 2'd2
    } state_t;

    // One-hot pad selection.
    typedef logic [1:0] sel_t;
    localparam sel_t SEL_NONE = 2'b00;
    localparam sel_t SEL_PAD0 = 2'b01;
    localparam sel_t SEL_PAD1 = 2'b10;

    // Pad byte bit positions (active-high).
    localparam int JOY_R    = 0;
    localparam int JOY_L    = 1;
    localparam int JOY_D    = 2;
    localparam int JOY_U    = 3;
    localparam int JOY_FIRE = 4;

    // VIA port A select bits.
    localparam int PA_SEL0 = 6;
    localparam int PA_SEL1 = 7;

    // Which pad the adapter is being asked for. sel_bits = {PA7, PA6}.
    // PASE gives PA7 priority; IJK only answers while the strobe is low
    // and gives PA6 priority.
    function automatic sel_t decode_sel(input adapter_t adp,
                                        input logic     strobe,
                                        input logic [1:0] sel_bits);
        sel_t s;
        s = SEL_NONE;
        case (adp)
            ADP_PASE: begin
                if (sel_bits[1])      s = SEL_PAD0;
                else if (sel_bits[0]) s = SEL_PAD1;
            end
            ADP_IJK: begin
                if (!strobe) begin
                    if (sel_bits[0])      s = SEL_PAD0;
                    else if (sel_bits[1]) s = SEL_PAD1;
                end
            end
            default: s = SEL_NONE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/joy_debounce.sv
// Per-pad 2-flop synchroniser followed by a stability counter on the synced byte.
// Latency: 2 clk sync + TICKS ce ticks of unchanged input before o_acc updates.
// Backpressure: none; free-running, any change of the synced byte restarts the count.
module joy_debounce #(
    parameter int TICKS = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce,
    input  logic [7:0] i_raw,
    output logic [7:0] o_acc
);

    logic [7:0] r_sync1;
    logic [7:0] r_sync2;
    logic [7:0] r_last;
    logic [7:0] r_acc;
    logic [3:0] r_cnt;

    // Bring the asynchronous pad byte into the clk_sys domain.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Restart on any change (every clock), count ce ticks only while the
    // candidate differs from the accepted byte, accept on the TICKS-th tick.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_last <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
        end else if (r_sync2 != r_last) begin
            r_last <= r_sync2;
            r_cnt  <= '0;
        end else if (ce && (r_last != r_acc)) begin
            if (r_cnt == 4'(TICKS - 1)) begin
                r_acc <= r_last;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/joy_port_ctrl.sv
// Oric VIA port A joystick overlay controller: debounce, autofire, pad select FSM, PASE/IJK map.
// Latency: outputs registered, 1 clk after state/data; pad edge = 2 clk + DEBOUNCE_TICKS ce + 1 clk.
// Backpressure: none; outputs are forced to zero while a selection change settles.
module joy_port_ctrl
    import joy_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 4,
    parameter int SETTLE_TICKS   = 2,
    parameter int AUTOFIRE_DIV   = 8192
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ce,
    input  logic [7:0] joystick_0,
    input  logic [7:0] joystick_1,
    input  logic [1:0] adapter,
    input  logic [1:0] autofire_en,
    input  logic       via_strobe,
    input  logic [7:0] via_pa_in,
    output logic [7:0] joy_mask,
    output logic [7:0] joy_value,
    output logic       ijk_present,
    output logic [1:0] sel_pad
);

    localparam int AFW = (AUTOFIRE_DIV > 2) ? $clog2(AUTOFIRE_DIV) : 1;

    logic [7:0]     w_acc0;
    logic [7:0]     w_acc1;
    logic [4:0]     w_eff0;
    logic [4:0]     w_eff1;
    logic [4:0]     w_pad;
    logic [AFW-1:0] r_af_cnt;
    logic           r_af_phase;

    adapter_t       w_adp;
    adapter_t       r_adp;
    logic           w_adp_chg;
    sel_t           w_raw_sel;
    sel_t           r_cur_sel;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_settle_load;
    logic           w_settle_inc;
    logic [3:0]     r_settle_cnt;

    logic           w_drive;
    logic           w_active;
    logic           w_ijk_bit;
    logic [7:0]     w_mask;
    sel_t           w_sel_out;

    logic [7:0]     r_mask;
    logic           r_ijk;
    sel_t           r_sel;

    logic           w_unused;

    joy_debounce #(.TICKS(DEBOUNCE_TICKS)) u_deb0 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ce      (ce),
        .i_raw   (joystick_0),
        .o_acc   (w_acc0)
    );

    joy_debounce #(.TICKS(DEBOUNCE_TICKS)) u_deb1 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ce      (ce),
        .i_raw   (joystick_1),
        .o_acc   (w_acc1)
    );

    // Shared autofire divider: phase flips every AUTOFIRE_DIV ce ticks.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_af_cnt   <= '0;
            r_af_phase <= 1'b0;
        end else if (ce) begin
            if (r_af_cnt == AFW'(AUTOFIRE_DIV - 1)) begin
                r_af_cnt   <= '0;
                r_af_phase <= ~r_af_phase;
            end else begin
                r_af_cnt <= r_af_cnt + 1'b1;
            end
        end
    end

    // Effective direction+fire bits; autofire gates fire with the shared phase.
    assign w_eff0 = {w_acc0[JOY_FIRE] & (~autofire_en[0] | r_af_phase), w_acc0[3:0]};
    assign w_eff1 = {w_acc1[JOY_FIRE] & (~autofire_en[1] | r_af_phase), w_acc1[3:0]};

    assign w_adp     = adapter_t'(adapter);
    assign w_adp_chg = (w_adp != r_adp);
    assign w_raw_sel = decode_sel(w_adp, via_strobe, {via_pa_in[PA_SEL1], via_pa_in[PA_SEL0]});

    // Track the adapter setting so a change can be seen on the next clock.
    always_ff @(posedge clk_sys) begin
        if (reset) r_adp <= ADP_NONE;
        else       r_adp <= w_adp;
    end

    // FSM state register.
    always_ff @(posedge clk_sys) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state: adapter change wins over a selection change; both are
    // checked every clock, only the settle count waits for ce.
    always_comb begin
        w_state_nxt   = r_state;
        w_settle_load = 1'b0;
        w_settle_inc  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((w_adp == ADP_PASE) || (w_adp == ADP_IJK)) begin
                    w_state_nxt   = ST_SETTLE;
                    w_settle_load = 1'b1;
                end
            end
            ST_SETTLE, ST_DRIVE: begin
                if (w_adp_chg) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_raw_sel != r_cur_sel) begin
                    w_state_nxt   = ST_SETTLE;
                    w_settle_load = 1'b1;
                end else if (r_state == ST_SETTLE) begin
                    if ((SETTLE_TICKS == 0) ||
                        (ce && (r_settle_cnt == 4'(SETTLE_TICKS - 1)))) begin
                        w_state_nxt = ST_DRIVE;
                    end else if (ce) begin
                        w_settle_inc = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Selection latch and settle counter, loaded whenever SETTLE is (re)entered.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cur_sel    <= SEL_NONE;
            r_settle_cnt <= '0;
        end else if (w_settle_load) begin
            r_cur_sel    <= w_raw_sel;
            r_settle_cnt <= '0;
        end else if (w_settle_inc) begin
            r_settle_cnt <= r_settle_cnt + 4'd1;
        end
    end

    // Pad map is only driven in a stable DRIVE: a pending adapter or
    // selection change blanks the outputs in the same clock it is seen.
    assign w_drive   = (r_state == ST_DRIVE) && !w_adp_chg && (w_raw_sel == r_cur_sel);
    assign w_active  = (r_state != ST_IDLE) && !w_adp_chg;
    assign w_ijk_bit = w_active && (w_adp == ADP_IJK) && !via_strobe;
    assign w_pad     = (r_cur_sel == SEL_PAD1) ? w_eff1 : w_eff0;
    assign w_sel_out = w_drive ? r_cur_sel : SEL_NONE;

    // Adapter-specific wiring of pad bits onto PA lines.
    always_comb begin
        w_mask = 8'h00;
        if (w_drive && (r_cur_sel != SEL_NONE)) begin
            case (w_adp)
                ADP_PASE: begin
                    w_mask[0] = w_pad[JOY_L];
                    w_mask[1] = w_pad[JOY_R];
                    w_mask[3] = w_pad[JOY_D];
                    w_mask[4] = w_pad[JOY_U];
                    w_mask[5] = w_pad[JOY_FIRE];
                end
                ADP_IJK: begin
                    w_mask[0] = w_pad[JOY_R];
                    w_mask[1] = w_pad[JOY_L];
                    w_mask[2] = w_pad[JOY_FIRE];
                    w_mask[3] = w_pad[JOY_D];
                    w_mask[4] = w_pad[JOY_U];
                end
                default: w_mask = 8'h00;
            endcase
        end
        w_mask[5] = w_mask[5] | w_ijk_bit;
    end

    // Output registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_mask <= '0;
            r_ijk  <= 1'b0;
            r_sel  <= SEL_NONE;
        end else begin
            r_mask <= w_mask;
            r_ijk  <= w_ijk_bit;
            r_sel  <= w_sel_out;
        end
    end

    assign joy_mask    = r_mask;
    assign joy_value   = 8'h00;
    assign ijk_present = r_ijk;
    assign sel_pad     = r_sel;

    // PA data bits and the upper pad bits have no role in the overlay.
    assign w_unused = ^{via_pa_in[5:0], w_acc0[7:5], w_acc1[7:5]};

endmodule

// File: tb/tb_joy_port_ctrl.sv
module tb_joy_port_ctrl;

    logic       clk_sys = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b1;
    logic [7:0] joystick_0 = '0;
    logic [7:0] joystick_1 = '0;
    logic [1:0] adapter = '0;
    logic [1:0] autofire_en = '0;
    logic       via_strobe = 1'b1;
    logic [7:0] via_pa_in = '0;
    logic [7:0] joy_mask;
    logic [7:0] joy_value;
    logic       ijk_present;
    logic [1:0] sel_pad;

    typedef struct {
        int         cyc;
        logic [7:0] mask;
        logic       ijk;
        logic [1:0] sel;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   ce_rand = 1'b0;

    always #5 clk_sys = ~clk_sys;

    joy_port_ctrl #(
        .DEBOUNCE_TICKS (4),
        .SETTLE_TICKS   (2),
        .AUTOFIRE_DIV   (4)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ce          (ce),
        .joystick_0  (joystick_0),
        .joystick_1  (joystick_1),
        .adapter     (adapter),
        .autofire_en (autofire_en),
        .via_strobe  (via_strobe),
        .via_pa_in   (via_pa_in),
        .joy_mask    (joy_mask),
        .joy_value   (joy_value),
        .ijk_present (ijk_present),
        .sel_pad     (sel_pad)
    );

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Clock enable: always high, or random but high at least every other clock.
    initial begin
        forever begin
            @(negedge clk_sys);
            ce = ce_rand ? ((cyc % 2 == 1) || ($urandom_range(0, 1) == 1)) : 1'b1;
        end
    end

    // Monitor: compare every expectation due at this cycle.
    initial begin
        forever begin
            @(posedge clk_sys);
            #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_tests++;
                if (joy_mask !== e.mask || ijk_present !== e.ijk ||
                    sel_pad !== e.sel || joy_value !== 8'h00) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d: got mask=%02h value=%02h ijk=%0b sel=%02b, want mask=%02h value=00 ijk=%0b sel=%02b",
                             e.name, cyc, joy_mask, joy_value, ijk_present, sel_pad,
                             e.mask, e.ijk, e.sel);
                end
            end
        end
    end

    task automatic expect_at(input int dly, input logic [7:0] m, input logic ijk,
                             input logic [1:0] s, input string nm);
        exp_t x;
        x.cyc  = cyc + dly;
        x.mask = m;
        x.ijk  = ijk;
        x.sel  = s;
        x.name = nm;
        sb.push_back(x);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Steady-state reference: what the overlay should show once inputs have
    // been stable long enough, autofire off.
    function automatic void model(input logic [1:0] adp, input logic [7:0] pa,
                                  input logic stb, input logic [7:0] j0,
                                  input logic [7:0] j1, output logic [7:0] m,
                                  output logic ijk, output logic [1:0] s);
        int pad;
        logic [7:0] p;
        pad = -1;
        m   = 8'h00;
        ijk = 1'b0;
        s   = 2'b00;
        if (adp == 2'd1) begin
            if (pa[7])      pad = 0;
            else if (pa[6]) pad = 1;
        end else if (adp == 2'd2 && !stb) begin
            ijk  = 1'b1;
            m[5] = 1'b1;
            if (pa[6])      pad = 0;
            else if (pa[7]) pad = 1;
        end
        if (pad >= 0) begin
            p = (pad == 0) ? j0 : j1;
            s = (pad == 0) ? 2'b01 : 2'b10;
            if (adp == 2'd1) begin
                m[0] = p[1]; m[1] = p[0]; m[3] = p[2]; m[4] = p[3]; m[5] = p[4];
            end else begin
                m[0] = p[0]; m[1] = p[1]; m[2] = p[4]; m[3] = p[2]; m[4] = p[3];
            end
        end
    endfunction

    initial begin
        logic       bits [40];
        int         last_t;
        int         toggles;
        logic [7:0] em;
        logic       ei;
        logic [1:0] es;

        // Reset state, with inputs already asking for pad 0 on PASE.
        adapter    = 2'd1;
        via_pa_in  = 8'h80;
        joystick_0 = 8'h01;
        step(3);
        expect_at(1, 8'h00, 1'b0, 2'b00, "reset_state");
        step(2);
        reset = 1'b0;

        // 1: PASE, pad 0 right -> mask bit 1.
        expect_at(40, 8'h02, 1'b0, 2'b01, "t1_pase_right");
        step(41);

        // 2: IJK fire on pad 0 plus presence; strobe high blanks next clk.
        adapter    = 2'd2;
        via_strobe = 1'b0;
        via_pa_in  = 8'h40;
        joystick_0 = 8'h10;
        expect_at(40, 8'h24, 1'b1, 2'b01, "t2_ijk_fire");
        step(41);
        via_strobe = 1'b1;
        expect_at(1, 8'h00, 1'b0, 2'b00, "t2_strobe_high");
        expect_at(30, 8'h00, 1'b0, 2'b00, "t2_strobe_steady");
        step(31);
        via_strobe = 1'b0;

        // 3: PASE selection changes, settle window, PA7 priority.
        adapter    = 2'd1;
        via_pa_in  = 8'h80;
        joystick_0 = 8'h01;
        joystick_1 = 8'h04;
        expect_at(40, 8'h02, 1'b0, 2'b01, "t3_pad0");
        step(41);
        via_pa_in = 8'h40;
        expect_at(1, 8'h00, 1'b0, 2'b00, "t3_settle_a");
        expect_at(2, 8'h00, 1'b0, 2'b00, "t3_settle_b");
        expect_at(8, 8'h08, 1'b0, 2'b10, "t3_pad1");
        step(9);
        via_pa_in = 8'hC0;
        expect_at(8, 8'h02, 1'b0, 2'b01, "t3_pa7_wins");
        step(9);

        // 4: short glitch is filtered, stable change accepted.
        for (int i = 1; i <= 30; i++) expect_at(i, 8'h02, 1'b0, 2'b01, "t4_glitch_hold");
        joystick_0 = 8'h00;
        step(2);
        joystick_0 = 8'h01;
        step(29);
        joystick_0 = 8'h00;
        expect_at(20, 8'h00, 1'b0, 2'b01, "t4_release");
        step(21);

        // 5: autofire toggles fire every 4 ce ticks; off -> steady fire.
        joystick_0  = 8'h10;
        autofire_en = 2'b01;
        step(30);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_sys);
            #1;
            bits[i] = joy_mask[5];
        end
        last_t  = -1;
        toggles = 0;
        for (int i = 1; i < 40; i++) begin
            if (bits[i] != bits[i-1]) begin
                if (last_t >= 0) begin
                    n_tests++;
                    if (i - last_t != 4) begin
                        n_fail++;
                        $display("FAIL t5_af_period: got %0d clocks between toggles, want 4", i - last_t);
                    end
                end
                last_t = i;
                toggles++;
            end
        end
        n_tests++;
        if (toggles < 8) begin
            n_fail++;
            $display("FAIL t5_af_toggles: got %0d toggles in 40 clocks, want >= 8", toggles);
        end
        step(1);
        autofire_en = 2'b00;
        for (int i = 2; i <= 11; i++) expect_at(i, 8'h20, 1'b0, 2'b01, "t5_af_off");
        step(12);

        // 6: reset in DRIVE, then adapter 2 -> 3.
        adapter    = 2'd2;
        via_strobe = 1'b0;
        via_pa_in  = 8'h40;
        joystick_0 = 8'h01;
        expect_at(40, 8'h21, 1'b1, 2'b01, "t6_drive");
        step(41);
        reset = 1'b1;
        expect_at(1, 8'h00, 1'b0, 2'b00, "t6_reset");
        step(1);
        reset = 1'b0;
        expect_at(40, 8'h21, 1'b1, 2'b01, "t6_redrive");
        step(41);
        adapter = 2'd3;
        expect_at(1, 8'h00, 1'b0, 2'b00, "t6_rsvd");
        expect_at(20, 8'h00, 1'b0, 2'b00, "t6_rsvd_idle");
        step(21);

        // Random steady-state patterns with random ce and pre-settling churn.
        ce_rand = 1'b1;
        repeat (40) begin
            repeat ($urandom_range(0, 5)) begin
                adapter    = 2'($urandom);
                via_pa_in  = 8'($urandom);
                via_strobe = 1'($urandom);
                joystick_0 = 8'($urandom);
                joystick_1 = 8'($urandom);
                step(1);
            end
            adapter    = 2'($urandom);
            via_pa_in  = 8'($urandom);
            via_strobe = 1'($urandom);
            joystick_0 = 8'($urandom);
            joystick_1 = 8'($urandom);
            model(adapter, via_pa_in, via_strobe, joystick_0, joystick_1, em, ei, es);
            expect_at(40, em, ei, es, "rand");
            step(41);
        end
        ce_rand = 1'b0;

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 100 && sb.size() > 0; i++) step(1);
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
